// File: rtl/pa_perips_timer.sv
// Memory-mapped machine timer on the core data bus: prescaled 32-bit up-counter
// with compare, W1C match flag and a level interrupt to the core.
module pa_perips_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFE0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dbus_addr_i,
  input  logic        dbus_rd_i,
  input  logic        dbus_we_i,
  input  logic [2:0]  dbus_size_i,
  input  logic [31:0] dbus_data_i,
  output logic [31:0] dbus_data_o,
  output logic        irq_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  logic [2:0]  ctrl_q,  ctrl_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q,   cmp_d;
  logic        pend_q,  pend_d;
  logic [15:0] pcnt_q,  pcnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sel, wr, rd, tick, match, count_wr, pend_set, pend_clr;
  logic [2:0]  off;
  logic [3:0]  be;
  logic [31:0] rmux;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  en);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = en[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    sel = ((dbus_addr_i & ADDR_MASK) == BASE_ADDR);
    wr  = dbus_we_i & sel;
    rd  = dbus_rd_i & sel;
    off = dbus_addr_i[4:2];
    case (dbus_size_i)
      3'b000:  be = 4'b0001 << dbus_addr_i[1:0];
      3'b001:  be = dbus_addr_i[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Read data always reflects pre-write state, so a combined rd+we returns the old value.
  always_comb begin
    case (off)
      OFF_CTRL:   rmux = {29'h0, ctrl_q};
      OFF_PRESC:  rmux = {16'h0, presc_q};
      OFF_COUNT:  rmux = count_q;
      OFF_CMP:    rmux = cmp_q;
      OFF_STATUS: rmux = {31'h0, pend_q};
      default:    rmux = 32'h0;
    endcase
    rdata_d = rd ? rmux : rdata_q;
  end

  always_comb begin
    tick     = ctrl_q[0] && (pcnt_q == presc_q);
    match    = (count_q == cmp_q);
    count_wr = wr && (off == OFF_COUNT);
    pend_set = tick && match && !count_wr;
    pend_clr = wr && (off == OFF_STATUS) && be[0] && dbus_data_i[0];

    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;
    if (wr && off == OFF_CTRL && be[0]) ctrl_d = dbus_data_i[2:0];
    if (wr && off == OFF_PRESC) begin
      if (be[0]) presc_d[7:0]  = dbus_data_i[7:0];
      if (be[1]) presc_d[15:8] = dbus_data_i[15:8];
    end
    if (wr && off == OFF_CMP) cmp_d = lane_merge(cmp_q, dbus_data_i, be);

    if (!ctrl_q[0])  pcnt_d = 16'h0;
    else if (tick)   pcnt_d = 16'h0;
    else             pcnt_d = pcnt_q + 16'd1;

    // A software write to COUNT overrides any tick in the same cycle.
    if (count_wr)                    count_d = lane_merge(count_q, dbus_data_i, be);
    else if (tick && match && ctrl_q[2]) count_d = 32'h0;
    else if (tick)                   count_d = count_q + 32'd1;
    else                             count_d = count_q;

    pend_d = pend_set | (pend_q & ~pend_clr);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q  <= 3'h0;
      presc_q <= 16'h0;
      count_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      pend_q  <= 1'b0;
      pcnt_q  <= 16'h0;
      rdata_q <= 32'h0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pend_q  <= pend_d;
      pcnt_q  <= pcnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign dbus_data_o = rdata_q;
  assign irq_o       = pend_q & ctrl_q[1];

endmodule

// File: doc/pa_perips_timer.md
# pa_perips_timer

Memory-mapped machine timer that is the responder on the core data bus (dbus) and the source of the core's `irq_i`. It decodes dbus read/write cycles addressed to its window, holds a prescaled 32-bit up-counter with compare, and raises a level interrupt on match. It sits in the SoC peripheral fabric beside the data RAM, behind the dbus address decoder.

## Interface

**Parameters**

- `BASE_ADDR`, default 32'h4000_0000: base of the 32-byte register window.
- `ADDR_MASK`, default 32'hFFFF_FFE0: selection mask. The block is selected when `(dbus_addr_i & ADDR_MASK) == BASE_ADDR`.

**Ports**

- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low; clock clk_i.
- `dbus_addr_i`  in  32  byte address from the core.
- `dbus_rd_i`  in  1  read strobe, one cycle per access.
- `dbus_we_i`  in  1  write strobe, one cycle per access.
- `dbus_size_i`  in  3  access size: 3'b000 byte, 3'b001 half, 3'b010 word. Other codes are treated as word.
- `dbus_data_i`  in  32  write data, lane-positioned (byte n on bits [8n+7:8n]).
- `dbus_data_o`  out  32  read data, full word, registered.
- `irq_o`  out  1  timer interrupt, level, to core `irq_i`.

## Operation

**Register map** (offset = `addr[4:2]`; unused offsets read 0 and ignore writes)

- 0x00 CTRL:
  - bit0 EN: counting enabled.
  - bit1 IE: interrupt enabled.
  - bit2 AR: auto-reload count to 0 on match.
  - Other bits read 0.
- 0x04 PRESCALE: bits[15:0], reload value of the divider. Upper bits read 0.
- 0x08 COUNT: 32-bit counter, R/W.
- 0x0C COMPARE: 32-bit compare value, R/W. Reset value 32'hFFFF_FFFF.
- 0x10 STATUS: bit0 PEND, the match flag. Writing 1 clears it; writing 0 has no effect.

**Writes** (when `dbus_we_i` and the block is selected)

- Byte lanes are enabled as follows:
  - byte: lane `addr[1:0]` only.
  - half: lanes {`addr[1]`*2, `addr[1]`*2+1}.
  - word: all four lanes.
- Only the enabled lanes of the target register update. This applies per lane to the W1C STATUS register as well.

**Reads** (when `dbus_rd_i` and the block is selected)

- `dbus_data_o` captures the full 32-bit register at the clock edge. The core's MAU performs sub-word extraction.
- `dbus_data_o` holds its value until the next selected read.
- Unselected cycles do not change `dbus_data_o`.
- If `dbus_rd_i` and `dbus_we_i` are both set, the write is performed and the read returns the pre-write value.

**Divider and counter**

- Internal 16-bit `pcnt` exists.
- When EN=1:
  - If `pcnt == PRESCALE`, then `tick = 1` and `pcnt` becomes 0.
  - Otherwise `pcnt` increments.
- When EN=0, `pcnt` is held at 0 and no ticks occur.
- PRESCALE=0 produces a tick every cycle.
- On a tick, with `COUNT == COMPARE`:
  - PEND is set.
  - COUNT becomes 0 if AR=1, otherwise COUNT+1.
- On a tick without a match, COUNT becomes COUNT+1, wrapping 32'hFFFF_FFFF to 0 with no flag.
- `irq_o = PEND & IE`, combinational from flops only (glitch-free).

**Simultaneous events**

- A software write to COUNT in the same cycle as a tick: the write wins, and no match is evaluated that cycle.
- A W1C of PEND in the same cycle as a new match: set wins, so PEND stays 1.
- A write to PRESCALE takes effect from the next comparison. `pcnt` is not reset; if `pcnt` exceeds the new PRESCALE, it counts up and wraps through 16'hFFFF.
- A write to CTRL with EN 1→0 clears `pcnt` on the following edge. COUNT is held.

## Timing

**Reset values**

- All registers are 0, except COMPARE = 32'hFFFF_FFFF.
- `pcnt` = 0, `dbus_data_o` = 0, `irq_o` = 0.
- Reset is asynchronous and may be asserted mid-operation. All state returns to the reset values immediately; no access is completed.

**Latencies**

- Writes: the register updates at the edge where `dbus_we_i` is sampled. A read issued in the next cycle observes the new value.
- Reads: one-cycle latency. The address and `dbus_rd_i` are sampled at edge N, and `dbus_data_o` is valid after edge N and through cycle N+1, matching the core's one-cycle-delayed data capture.
- Counting: with EN set at edge N and PRESCALE=P, the first tick occurs in the cycle after edge N+P, and COUNT increments at edge N+P+1. COUNT advances once every P+1 cycles.
- Interrupt: PEND sets at the tick edge where COUNT==COMPARE, and `irq_o` rises in the same cycle that PEND becomes visible. A STATUS W1C drops `irq_o` the cycle after the write.

**Handshake**

- There is no wait state and no handshake.
- Every access completes in one cycle. Back-to-back accesses on consecutive cycles must be supported.

## Test plan

- **Reset / readback:** after reset, read each of the five offsets. Required results: 0, 0, 0, 32'hFFFF_FFFF, 0, and `irq_o` = 0. Write 32'hA5A5_1234 to PRESCALE and read it back as 32'h0000_1234.
- **Prescaled count:** set PRESCALE=3 and CTRL=1, wait 40 cycles, then read COUNT. Required value: 10 (±1 depending on read sampling). Then write CTRL=0, wait 20 cycles, and require COUNT unchanged.
- **Match + IRQ:** set COMPARE=5, PRESCALE=0, CTRL=3'b111.
  - Required: `irq_o` rises on the cycle after COUNT==5 is ticked, and COUNT reads 0 then increments.
  - Write STATUS=1: `irq_o` drops one cycle later and re-asserts on the next match.
- **Sub-word writes:** write COUNT with 32'hFFFF_FFFF, then a byte write of 8'h12 at offset 0x09 (lane 1, data 32'h0000_1200) with EN=0. Required read: 32'hFFFF_12FF. A half write at offset 0x0A with data 32'hABCD_0000 then yields 32'hABCD_12FF.
- **Collisions:**
  - PEND set in the same cycle as a STATUS W1C: PEND remains 1.
  - A COUNT write of 100 in the same cycle as a tick: COUNT reads 100 on the next cycle.
  - Wrap: COUNT=32'hFFFF_FFFF with COMPARE=7 ticks to 0 with no PEND.
- **Async reset mid-count:** with EN=1 and PEND=1, pulse `rst_n_i` low for half a cycle. Required: `irq_o` falls immediately, all registers read their reset values, and `dbus_data_o` = 0.
